// File: rtl/mand_dispatcher.sv
// mand_dispatcher: walks every pixel of a WIDTH x HEIGHT frame, launches the
// Mandelbrot solver with the pixel's complex coordinate, waits for the
// iteration count and hands it to the frame buffer with a valid/ready write.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle frame request, honoured only when idle
//   re_min, im_max, step  signed 4.23 frame origin (left column, top row) and pitch
//   solver_reset          restart strobe to the solver; solver samples c while high
//   c_re, c_im            signed 4.23 coordinate of the current pixel
//   solver_ready          solver result valid
//   solver_out            signed iteration count (-1 = converged)
//   wr_valid, wr_ready    frame-buffer write handshake
//   wr_x, wr_y, wr_data   pixel address and result being written
//   busy                  frame in progress (LAUNCH through DONE)
//   done                  one-cycle end-of-frame pulse
//
// Optional build macro MAND_DISP_TIMEOUT_EN: bounds each WAIT to
// TIMEOUT_CYCLES cycles and writes -2 for a pixel whose solver never answers.
module mand_dispatcher #(
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [26:0] re_min,
    input  logic signed [26:0] im_max,
    input  logic signed [26:0] step,
    output logic               solver_reset,
    output logic signed [26:0] c_re,
    output logic signed [26:0] c_im,
    input  logic               solver_ready,
    input  logic signed [31:0] solver_out,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [9:0]         wr_x,
    output logic [9:0]         wr_y,
    output logic [31:0]        wr_data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned XW = 10;
    localparam int unsigned DW = 32;

    // Elaboration-time guard on the supported frame geometry.
    if (WIDTH < 2 || WIDTH > 1023 || HEIGHT < 2 || HEIGHT > 1023 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mand_dispatcher: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [XW-1:0]      x;
    logic [XW-1:0]      y;
    logic signed [26:0] re_min_q;
    logic signed [26:0] step_q;

    logic solver_reset_d;
    logic wr_valid_d;
    logic busy_d;
    logic done_d;

    logic last_col_c;
    logic last_row_c;
    logic timeout_c;

    assign last_col_c = (x == XW'(WIDTH - 1));
    assign last_row_c = (y == XW'(HEIGHT - 1));

`ifdef MAND_DISP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // The cycle that would bring the count to TIMEOUT_CYCLES is the last WAIT cycle.
    assign timeout_c = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Per-pixel WAIT cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State register plus registered control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            solver_reset <= 1'b1;
            wr_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            solver_reset <= solver_reset_d;
            wr_valid     <= wr_valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (solver_ready || timeout_c) state_next = S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    state_next = (last_col_c && last_row_c) ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track the state.
    always_comb begin
        solver_reset_d = 1'b1;
        wr_valid_d     = 1'b0;
        busy_d         = 1'b1;
        done_d         = 1'b0;
        case (state_next)
            S_IDLE:  busy_d         = 1'b0;
            S_WAIT:  solver_reset_d = 1'b0;
            S_WRITE: wr_valid_d     = 1'b1;
            S_DONE:  done_d         = 1'b1;
            default: ;
        endcase
    end

    // Pixel walker and write payload; coordinates advance by add/subtract with wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            re_min_q <= '0;
            step_q   <= '0;
            c_re     <= '0;
            c_im     <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        re_min_q <= re_min;
                        step_q   <= step;
                        x        <= '0;
                        y        <= '0;
                        c_re     <= re_min;
                        c_im     <= im_max;
                    end
                end
                S_WAIT: begin
                    // A real answer wins over a timeout in the same cycle.
                    if (solver_ready) begin
                        wr_data <= DW'(solver_out);
                        wr_x    <= x;
                        wr_y    <= y;
                    end else if (timeout_c) begin
                        wr_data <= 32'hFFFF_FFFE;
                        wr_x    <= x;
                        wr_y    <= y;
                    end
                end
                S_WRITE: begin
                    if (wr_ready && !(last_col_c && last_row_c)) begin
                        if (!last_col_c) begin
                            x    <= x + XW'(1);
                            c_re <= c_re + step_q;
                        end else begin
                            x    <= '0;
                            c_re <= re_min_q;
                            y    <= y + XW'(1);
                            c_im <= c_im - step_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mand_dispatcher.sv
module tb_mand_dispatcher;

    localparam int unsigned W = 2;
    localparam int unsigned H = 2;
`ifdef MAND_DISP_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1024;
`endif

    // 4.23 constants: -2.0, 1.0, 0.5, -1.5
    localparam int RE_MIN = -16777216;
    localparam int IM_MAX = 8388608;
    localparam int STEP   = 4194304;
    localparam int RE_1   = -12582912;
    localparam int IM_1   = 4194304;

    logic               clock;
    logic               reset;
    logic               start;
    logic signed [26:0] re_min;
    logic signed [26:0] im_max;
    logic signed [26:0] step;
    logic               solver_reset;
    logic signed [26:0] c_re;
    logic signed [26:0] c_im;
    logic               solver_ready;
    logic signed [31:0] solver_out;
    logic               wr_valid;
    logic               wr_ready;
    logic [9:0]         wr_x;
    logic [9:0]         wr_y;
    logic [31:0]        wr_data;
    logic               busy;
    logic               done;

    mand_dispatcher #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .re_min       (re_min),
        .im_max       (im_max),
        .step         (step),
        .solver_reset (solver_reset),
        .c_re         (c_re),
        .c_im         (c_im),
        .solver_ready (solver_ready),
        .solver_out   (solver_out),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    int total = 0;
    int bad   = 0;

    int lat         = 4;
    bit never_ready = 1'b0;
    int scnt        = 0;
    int max_cnt     = 0;
    int done_cnt    = 0;

    int          wq_x[$];
    int          wq_y[$];
    logic [31:0] wq_d[$];
    int          cq_re[$];
    int          cq_im[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Solver model: counts cycles out of reset, answers x+2y derived from the sampled c.
    initial begin
        solver_ready = 1'b0;
        solver_out   = '0;
        forever begin
            @(negedge clock);
            if (solver_reset) begin
                scnt         = 0;
                solver_ready = 1'b0;
            end else begin
                scnt++;
                if (scnt > max_cnt) max_cnt = scnt;
                if (scnt == 1) begin
                    cq_re.push_back(int'(c_re));
                    cq_im.push_back(int'(c_im));
                    solver_out = 32'((int'(c_re) - RE_MIN) / STEP + 2 * ((IM_MAX - int'(c_im)) / STEP));
                end
                solver_ready = !never_ready && (scnt >= lat);
            end
        end
    end

    // Write and done monitor.
    initial begin
        forever begin
            @(negedge clock);
            if (wr_valid && wr_ready) begin
                wq_x.push_back(int'(wr_x));
                wq_y.push_back(int'(wr_y));
                wq_d.push_back(wr_data);
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_logs();
        wq_x.delete();
        wq_y.delete();
        wq_d.delete();
        cq_re.delete();
        cq_im.delete();
    endtask

    // which: 0 = solver_reset low, 1 = done high, 2 = wr_valid high
    task automatic wait_for(input int which, input int limit, input string tag);
        int  t;
        bit  hit;
        t   = 0;
        hit = 1'b0;
        while (!hit && t < limit) begin
            case (which)
                0:       hit = (solver_reset == 1'b0);
                1:       hit = (done == 1'b1);
                default: hit = (wr_valid == 1'b1);
            endcase
            if (!hit) begin
                @(posedge clock);
                #1;
                t++;
            end
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_for(1, 20000, {tag, "_done_seen"});
        @(posedge clock);
        #1;
    endtask

    // Frame contents: 4 writes in raster order, data x+2y or -2 on timeout.
    task automatic check_frame(input string tag, input bit timed_out);
        check({tag, "_nwr"}, 32'(wq_x.size()), 32'd4);
        if (wq_x.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_x%0d", tag, i), 32'(wq_x[i]), 32'(i % 2));
                check($sformatf("%s_y%0d", tag, i), 32'(wq_y[i]), 32'(i / 2));
                check($sformatf("%s_d%0d", tag, i), wq_d[i], timed_out ? 32'hFFFF_FFFE : 32'(i));
            end
        end
    endtask

    int d0;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        wr_ready = 1'b1;
        re_min   = 27'(RE_MIN);
        im_max   = 27'(IM_MAX);
        step     = 27'(STEP);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_solver_reset", 32'(solver_reset), 32'd1);
        check("rst_wr_valid",     32'(wr_valid),     32'd0);
        check("rst_done",         32'(done),         32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_wr_x",         32'(wr_x),         32'd0);
        check("rst_wr_y",         32'(wr_y),         32'd0);
        check("rst_wr_data",      wr_data,           32'd0);
        check("rst_c_re",         32'(c_re),         32'd0);
        check("rst_c_im",         32'(c_im),         32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic 2x2 frame
        clear_logs();
        d0 = done_cnt;
        run_frame("f1");
        check_frame("f1", 1'b0);
        check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f1_ncp", 32'(cq_re.size()), 32'd4);
        if (cq_re.size() == 4) begin
            check("f1_c0re", 32'(cq_re[0]), 32'(RE_MIN));
            check("f1_c0im", 32'(cq_im[0]), 32'(IM_MAX));
            check("f1_c1re", 32'(cq_re[1]), 32'(RE_1));
            check("f1_c1im", 32'(cq_im[1]), 32'(IM_MAX));
            check("f1_c2re", 32'(cq_re[2]), 32'(RE_MIN));
            check("f1_c2im", 32'(cq_im[2]), 32'(IM_1));
            check("f1_c3re", 32'(cq_re[3]), 32'(RE_1));
            check("f1_c3im", 32'(cq_im[3]), 32'(IM_1));
        end
        check("f1_idle_busy", 32'(busy), 32'd0);

        // Back-pressure: wr_ready low for 4 cycles in WRITE
        clear_logs();
        d0 = done_cnt;
        wr_ready = 1'b0;
        pulse_start();
        wait_for(2, 200, "bp_wr_valid_seen");
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("bp_valid%0d", k),  32'(wr_valid),     32'd1);
            check($sformatf("bp_x%0d", k),      32'(wr_x),         32'd0);
            check($sformatf("bp_y%0d", k),      32'(wr_y),         32'd0);
            check($sformatf("bp_data%0d", k),   wr_data,           32'd0);
            check($sformatf("bp_sreset%0d", k), 32'(solver_reset), 32'd1);
            check($sformatf("bp_c_re%0d", k),   32'(c_re),         32'(RE_MIN));
            @(posedge clock);
            #1;
        end
        check("bp_nwr_held", 32'(wq_x.size()), 32'd0);
        wr_ready = 1'b1;
        wait_for(1, 2000, "bp_done_seen");
        @(posedge clock);
        #1;
        check_frame("bp", 1'b0);
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

        // start pulses during WAIT and DONE are ignored
        clear_logs();
        d0 = done_cnt;
        pulse_start();
        wait_for(0, 200, "ig_wait_seen");
        pulse_start();
        wait_for(1, 2000, "ig_done_seen");
        pulse_start();
        repeat (20) @(posedge clock);
        #1;
        check("ig_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("ig_nwr",      32'(wq_x.size()),   32'd4);
        check("ig_busy",     32'(busy),          32'd0);

        // Reset in WAIT of pixel (1,0)
        clear_logs();
        d0 = done_cnt;
        pulse_start();
        wait_for(2, 200, "rw_p0_write");
        wait_for(0, 200, "rw_p1_wait");
        check("rw_p1_c_re", 32'(c_re), 32'(RE_1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rw_wr_valid",     32'(wr_valid),     32'd0);
        check("rw_busy",         32'(busy),         32'd0);
        check("rw_solver_reset", 32'(solver_reset), 32'd1);
        check("rw_done",         32'(done),         32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rw_no_done", 32'(done_cnt - d0), 32'd0);
        check("rw_nwr",     32'(wq_x.size()),   32'd1);
        clear_logs();
        run_frame("rs");
        check_frame("rs", 1'b0);
        check("rs_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Long or absent solver answer
        clear_logs();
        d0      = done_cnt;
        max_cnt = 0;
`ifdef MAND_DISP_TIMEOUT_EN
        never_ready = 1'b1;
        run_frame("to");
        check_frame("to", 1'b1);
        check("to_wait_cycles", 32'(max_cnt), 32'd8);
        never_ready = 1'b0;
`else
        lat = 1000;
        run_frame("lg");
        check_frame("lg", 1'b0);
        check("lg_wait_cycles", 32'(max_cnt), 32'd1000);
        lat = 4;
`endif
        check("last_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mand_dispatcher.md
MAND_DISPATCHER -- requirements
Module: mand_dispatcher

Interface
REQ-001 Parameter WIDTH, 640, pixels per row (2..1023).
REQ-002 Parameter HEIGHT, 480, rows per frame (2..1023).
REQ-003 Parameter TIMEOUT_CYCLES, 1024, max solver cycles per pixel; used only with MAND_DISP_TIMEOUT_EN.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to render a frame; honoured only in IDLE.
REQ-007 re_min  in  27  signed 4.23 fixed-point real part of the left column.
REQ-008 im_max  in  27  signed 4.23 imaginary part of the top row.
REQ-009 step  in  27  signed 4.23 pixel pitch, both axes.
REQ-010 solver_reset  out  1  restart strobe to the Mandelbrot solver; solver samples c while high.
REQ-011 c_re, c_im  out  27 each  signed 4.23 point for the current pixel.
REQ-012 solver_ready  in  1  solver result valid.
REQ-013 solver_out  in  32  signed iteration count, -1 means converged.
REQ-014 wr_valid  out  1; wr_ready  in  1  frame-buffer write handshake.
REQ-015 wr_x, wr_y  out  10 each  pixel address; wr_data  out  32  result.
REQ-016 busy  out  1  high from the cycle after an accepted start through DONE; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-017 States: IDLE, LAUNCH, WAIT, WRITE, DONE; all outputs registered.
REQ-018 IDLE: start=1 latches re_min/im_max/step and sets x=0, y=0, c_re=re_min, c_im=im_max; next LAUNCH. start in any other state is ignored.
REQ-019 solver_reset=1 in IDLE, LAUNCH, WRITE, DONE; 0 only in WAIT.
REQ-020 LAUNCH lasts exactly one cycle; c_re/c_im are stable during it; solver_ready is not sampled; next WAIT.
REQ-021 WAIT: solver_ready=1 captures solver_out into wr_data in that same edge; next WRITE.
REQ-022 WRITE: wr_valid=1 with wr_x=x, wr_y=y; wr_x, wr_y, wr_data stay stable until wr_valid && wr_ready; wr_valid is low in every other state.
REQ-023 On accepted write, when x<WIDTH-1: x+=1, c_re+=step; next LAUNCH.
REQ-024 On accepted write, when x=WIDTH-1 and y<HEIGHT-1: x=0, c_re=re_min, y+=1, c_im-=step; next LAUNCH.
REQ-025 On accepted write of pixel (WIDTH-1, HEIGHT-1): next DONE.
REQ-026 DONE: done=1 for one cycle, busy=1; next IDLE; start during DONE is ignored.
REQ-027 Coordinates are computed incrementally by add/subtract, not by multiply; 27-bit two's-complement wrap, no saturation.
REQ-028 Pixel cost: 1 LAUNCH + N WAIT + at least 1 WRITE cycle; with wr_ready held high, minimum 3 cycles per pixel.

Reset
REQ-029 Reset values: state=IDLE, solver_reset=1, wr_valid=0, done=0, busy=0, x=y=0, wr_x=wr_y=0, wr_data=0, c_re=c_im=0.
REQ-030 Reset mid-frame aborts without a write or a done pulse; reset takes priority over start, solver_ready and wr_ready in the same cycle.

Configuration
REQ-031 Macro MAND_DISP_TIMEOUT_EN defined: a wait counter clears on LAUNCH and increments each WAIT cycle.
REQ-032 With the macro, when the count reaches TIMEOUT_CYCLES without solver_ready: wr_data=32'hFFFFFFFE (-2), then WRITE.
REQ-033 With the macro, solver_ready takes priority over timeout if both occur in the same cycle.
REQ-034 Macro undefined: no counter logic; WAIT lasts until solver_ready.

Verification
REQ-035 WIDTH=2, HEIGHT=2, re_min=-2.0, im_max=1.0, step=0.5, wr_ready=1, model solver answers 5 cycles after LAUNCH with out=x+2y. Required: writes (0,0,0), (1,0,1), (0,1,2), (1,1,3); c pairs (-2,1), (-1.5,1), (-2,0.5), (-1.5,0.5); one done pulse.
REQ-036 wr_ready low for 4 cycles in WRITE. Required: wr_valid, wr_x, wr_y, wr_data held constant; solver_reset=1 throughout; no advance.
REQ-037 start pulses during WAIT and DONE. Required: ignored; frame count and write count unchanged.
REQ-038 Reset asserted in WAIT of pixel (1,0). Required: next cycle in IDLE, wr_valid=0, busy=0, solver_reset=1; no done pulse; a new start restarts at (0,0).
REQ-039 Macro defined, TIMEOUT_CYCLES=8, solver never ready. Required: wr_data=-2 entering WRITE after 8 WAIT cycles; frame completes.
REQ-040 Macro undefined, solver ready after 1000 cycles. Required: no timeout; wr_data equals solver_out.
